// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin arbiter that shares one multi-cycle IEEE-754
// single-precision adder core among NREQ requesters. One operation is in
// flight at a time; a watchdog abandons operations whose core never finishes.
//
// Handshakes: a requester holds req_valid_i[i] with stable operands until it
// sees req_ready_o[i] high in a cycle; that cycle is the acceptance cycle and
// the request is consumed at the closing clock edge. Results come back as a
// single-cycle rsp_valid_o[i] pulse with rsp_result_o/rsp_flags_o valid in
// that same cycle; there is no back-pressure on responses.
module fp_add_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [32*NREQ-1:0]   req_a_i,
  input  logic [32*NREQ-1:0]   req_b_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic [NREQ-1:0]      rsp_valid_o,
  output logic [31:0]          rsp_result_o,
  output logic [3:0]           rsp_flags_o,
  output logic                 add_start_o,
  output logic [31:0]          add_a_o,
  output logic [31:0]          add_b_o,
  output logic                 add_rst_n_o,
  input  logic [31:0]          add_result_i,
  input  logic [3:0]           add_done_i,
  output logic [2:0]           dbg_state_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_DRAIN   = 3'd2,
    S_RESP    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   owner_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     add_a_q, add_b_q;
  logic [31:0]     rsp_result_q;
  logic [3:0]      rsp_flags_q;

  logic            grant_found;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   rr_next;
  logic            accept;

  // Round-robin pick: first requesting index at or after rr_ptr_q, wrapping.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(idx);
      end
    end
  end

  assign accept  = (state_q == S_IDLE) && grant_found;
  assign rr_next = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);

  // Next-state logic; a done on the final watchdog cycle still wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (grant_found) state_d = S_ISSUE;
      S_ISSUE: begin
        if (add_done_i[0])                      state_d = S_DRAIN;
        else if (cnt_q == CW'(TIMEOUT - 1))     state_d = S_RECOVER;
      end
      S_DRAIN:   state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      S_RECOVER: state_d = S_RESP;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; all strobes are forced low while rst is high.
  always_comb begin
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    add_start_o  = 1'b0;
    add_rst_n_o  = 1'b1;
    if (accept && !rst)
      req_ready_o = NREQ'(1) << grant_idx;
    if ((state_q == S_RESP) && !rst)
      rsp_valid_o = NREQ'(1) << owner_q;
    if (((state_q == S_ISSUE) || (state_q == S_DRAIN)) && !rst)
      add_start_o = 1'b1;
    if (rst || (state_q == S_RECOVER))
      add_rst_n_o = 1'b0;
  end

  assign add_a_o      = add_a_q;
  assign add_b_o      = add_b_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_flags_o  = rsp_flags_q;
  assign dbg_state_o  = state_q;

  // State, arbitration pointer, operand latches, watchdog and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == S_ISSUE) ? cnt_q + CW'(1) : '0;
      if (accept) begin
        owner_q  <= grant_idx;
        rr_ptr_q <= rr_next;
        add_a_q  <= req_a_i[32*int'(grant_idx) +: 32];
        add_b_q  <= req_b_i[32*int'(grant_idx) +: 32];
      end
      if ((state_q == S_ISSUE) && add_done_i[0]) begin
        rsp_result_q <= add_result_i;
        rsp_flags_q  <= {add_done_i[3:1], 1'b0};
      end else if (state_q == S_RECOVER) begin
        rsp_result_q <= '0;
        rsp_flags_q  <= 4'b0001;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: drives fp_add_arbiter against a behavioural adder core
// that finishes 9 cycles after its start goes high, and checks grants,
// responses and timing against an expected-result queue.
module tb_fp_add_arbiter;

  localparam int W = 44; // {idx[1:0], result[31:0], flags[3:0], latency[5:0]}

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   req_valid;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_ready, rsp_valid;
  logic [31:0]  rsp_result;
  logic [3:0]   rsp_flags;
  logic         add_start, add_rst_n;
  logic [31:0]  add_a, add_b, add_result;
  logic [3:0]   add_done;
  logic [2:0]   dbg_state;

  fp_add_arbiter #(.NREQ(4), .TIMEOUT(31)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_result_o (rsp_result),
    .rsp_flags_o  (rsp_flags),
    .add_start_o  (add_start),
    .add_a_o      (add_a),
    .add_b_o      (add_b),
    .add_rst_n_o  (add_rst_n),
    .add_result_i (add_result),
    .add_done_i   (add_done),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- behavioural adder core ----------------
  // Returns {over, under, zero, result} for the operand pairs used here.
  function automatic logic [34:0] core_fn(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] key;
    key = {a, b};
    case (key)
      {32'h3F800000, 32'h40000000}: core_fn = {3'b000, 32'h40400000}; // 1+2=3
      {32'h3F800000, 32'h3F800000}: core_fn = {3'b000, 32'h40000000}; // 1+1=2
      {32'h40000000, 32'h40000000}: core_fn = {3'b000, 32'h40800000}; // 2+2=4
      {32'h3FC00000, 32'h3FC00000}: core_fn = {3'b000, 32'h40400000}; // 1.5+1.5=3
      {32'h40400000, 32'h3F800000}: core_fn = {3'b000, 32'h40800000}; // 3+1=4
      {32'h3F800000, 32'hBF800000}: core_fn = {3'b001, 32'h00000000}; // 1-1=0
      {32'h7F7FFFFF, 32'h7F7FFFFF}: core_fn = {3'b100, 32'h7F800000}; // max+max=inf
      {32'h00800000, 32'h80C00000}: core_fn = {3'b010, 32'h80000000}; // flush to -0
      default:                      core_fn = {3'b000, a ^ b};
    endcase
  endfunction

  logic [4:0]  core_cnt;
  logic        core_hang;
  logic        core_done;
  logic [34:0] core_out;

  always_ff @(posedge clk) begin
    if (!add_rst_n || !add_start) core_cnt <= '0;
    else                          core_cnt <= core_cnt + 5'd1;
  end

  assign core_out   = core_fn(add_a, add_b);
  assign core_done  = add_start && add_rst_n && !core_hang && (core_cnt == 5'd9);
  assign add_result = core_out[31:0];
  assign add_done   = {core_out[34:32] & {3{core_done}}, core_done};

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc      = 0;
  int last_acc = 0;
  logic [3:0] last_acc_vec;
  logic acc_seen, have_prev, burst, chk_rv;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b);
    logic [34:0] m;
    req_valid[i]        = 1'b1;
    req_a[32*i +: 32]   = a;
    req_b[32*i +: 32]   = b;
    if (core_hang) begin
      exp_q.push_back({2'(i), 32'h0, 4'b0001, 6'd33});
    end else begin
      m = core_fn(a, b);
      exp_q.push_back({2'(i), m[31:0], m[34:32], 1'b0, 6'd12});
    end
  endtask

  // One clock cycle: sample everything at the falling edge, then retire
  // accepted requests just after the rising edge.
  task automatic tick();
    logic [3:0]   acc;
    logic [W-1:0] e;
    @(negedge clk);
    cyc++;
    acc = req_ready;
    if (rst) begin
      check("rstn_in_rst", add_rst_n, 1'b0);
      check("ready_in_rst", req_ready, 4'b0);
      check("rsp_in_rst", rsp_valid, 4'b0);
    end else begin
      if (chk_rv) begin
        chk_rv = 1'b0;
        check("rv_state", dbg_state, 3'd0);
        check("rv_ready", req_ready, 4'b0);
        check("rv_rsp_valid", rsp_valid, 4'b0);
        check("rv_rsp_result", rsp_result, 32'h0);
        check("rv_rsp_flags", rsp_flags, 4'h0);
        check("rv_add_start", add_start, 1'b0);
        check("rv_add_a", add_a, 32'h0);
        check("rv_add_b", add_b, 32'h0);
        check("rv_add_rst_n", add_rst_n, 1'b1);
      end
      if (acc != 4'b0) begin
        check("ready_onehot", $onehot(acc), 1'b1);
        check("ready_without_req", acc & ~req_valid, 4'b0);
        if (exp_q.size() == 0) check("grant_unexpected", acc, 4'b0);
        else                   check("grant_idx", acc, 4'b1 << exp_q[0][43:42]);
        if (burst && have_prev) check("grant_gap", cyc - last_acc, 13);
        have_prev    = 1'b1;
        last_acc     = cyc;
        last_acc_vec = acc;
        acc_seen     = 1'b1;
      end
      if (add_done[0]) check("done_lat", cyc - last_acc, 10);
      if (!add_rst_n) begin
        check("recover_lat", cyc - last_acc, 32);
        check("recover_start", add_start, 1'b0);
      end
      if (rsp_valid != 4'b0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 4'b0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_valid", rsp_valid, 4'b1 << e[43:42]);
          check("rsp_result", rsp_result, e[41:10]);
          check("rsp_flags", rsp_flags, e[9:6]);
          check("rsp_lat", cyc - last_acc, e[5:0]);
        end
      end
    end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic wait_grant(input int budget);
    acc_seen = 1'b0;
    for (int n = 0; n < budget && !acc_seen; n++) tick();
    if (!acc_seen) check("grant_wait", 1'b0, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_wait", exp_q.size(), 0);
    repeat (2) tick();
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst       = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
    have_prev = 1'b0;
    burst     = 1'b0;
    chk_rv    = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    core_hang = 1'b0; last_acc_vec = '0;
    acc_seen = 1'b0; have_prev = 1'b0; burst = 1'b0; chk_rv = 1'b0;
    do_reset();

    // Single operation from requester 2: 1.0 + 2.0.
    send(2, 32'h3F800000, 32'h40000000);
    wait_done(40);

    // All four at once from reset: grants 0,1,2,3 spaced 13 cycles apart,
    // covering zero, overflow and underflow flags.
    do_reset();
    burst = 1'b1;
    send(0, 32'h3F800000, 32'h3F800000);
    send(1, 32'h3F800000, 32'hBF800000);
    send(2, 32'h7F7FFFFF, 32'h7F7FFFFF);
    send(3, 32'h00800000, 32'h80C00000);
    wait_done(80);

    // Fairness: requesters 0 and 3 kept requesting alternate 0,3,0,3,...
    do_reset();
    burst = 1'b1;
    send(0, 32'h40000000, 32'h40000000);
    send(3, 32'h3FC00000, 32'h3FC00000);
    for (int n = 0; n < 6; n++) begin
      wait_grant(40);
      if (n < 4) begin
        if (last_acc_vec[0]) send(0, 32'h40000000, 32'h40000000);
        else                 send(3, 32'h3FC00000, 32'h3FC00000);
      end
    end
    wait_done(60);

    // Watchdog: a core that never finishes.
    do_reset();
    core_hang = 1'b1;
    send(1, 32'h3F800000, 32'h40000000);
    wait_done(60);
    core_hang = 1'b0;

    // Reset in the middle of an operation, then a fresh one.
    do_reset();
    send(1, 32'h40000000, 32'h40000000);
    wait_grant(10);
    repeat (4) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst    = 1'b0;
    chk_rv = 1'b1;
    repeat (3) tick();
    send(1, 32'h3FC00000, 32'h3FC00000);
    wait_done(40);

    // Back-to-back from one requester, plus a request withdrawn unserved.
    do_reset();
    burst = 1'b1;
    send(2, 32'h40400000, 32'h3F800000);
    wait_grant(10);
    repeat (3) tick();
    req_valid[0] = 1'b1;
    repeat (3) tick();
    req_valid[0] = 1'b0;
    repeat (4) tick();
    send(2, 32'h3F800000, 32'h3F800000);
    wait_done(40);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog against a stuck bench.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing one adder core.
REQ-002 Parameter: TIMEOUT, 31, maximum ISSUE cycles before the operation is abandoned.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 req_valid  in  NREQ  per-requester operation request, held until accepted.
REQ-006 req_a  in  32*NREQ  IEEE-754 single operand A; requester i uses bits [32i+31:32i].
REQ-007 req_b  in  32*NREQ  operand B, same packing.
REQ-008 req_ready  out  NREQ  one-hot acceptance pulse.
REQ-009 rsp_valid  out  NREQ  one-hot, one-cycle result pulse to the owning requester.
REQ-010 rsp_result  out  32  result word, valid while rsp_valid is nonzero.
REQ-011 rsp_flags  out  4  {over, under, zero, timeout}, valid with rsp_valid.
REQ-012 add_start  out  1  level enable to adder core (Start_Sig).
REQ-013 add_a, add_b  out  32 each  operands to adder core.
REQ-014 add_rst_n  out  1  active-low reset to adder core.
REQ-015 add_result  in  32  adder Result.
REQ-016 add_done  in  4  adder Done_Sig {isOver, isUnder, isZero, isDone}.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, DRAIN, RESP, RECOVER.
REQ-018 IDLE: if any req_valid set, grant exactly one requester, pulse its req_ready, latch its operands into add_a/add_b and its index into owner, go to ISSUE.
REQ-019 Arbitration SHALL be round-robin: grant the first requesting index at or after rr_ptr (mod NREQ); after a grant, rr_ptr = granted+1 mod NREQ.
REQ-020 add_a/add_b SHALL remain stable from the grant until the next grant.
REQ-021 add_start SHALL be 1 in ISSUE and DRAIN, 0 in every other state.
REQ-022 ISSUE: on add_done[0]=1, capture add_result and add_done[3:1] into rsp registers, go to DRAIN.
REQ-023 DRAIN lasts exactly 1 cycle so the core step counter returns to 0; then go to RESP.
REQ-024 RESP: assert rsp_valid[owner] for exactly 1 cycle with timeout flag 0; go to IDLE.
REQ-025 Nominal latency: acceptance cycle T, add_done[0] seen at T+10, rsp_valid at T+12; next grant no earlier than T+13.
REQ-026 ISSUE cycle counter SHALL count from 0 at ISSUE entry; reaching TIMEOUT without add_done[0] SHALL go to RECOVER.
REQ-027 RECOVER lasts 1 cycle: add_rst_n=0, add_start=0; then RESP with rsp_result=0 and rsp_flags=4'b0001.
REQ-028 add_rst_n = ~rst AND NOT(state==RECOVER).
REQ-029 Requests arriving while not in IDLE SHALL wait; no request may be dropped or granted twice.
REQ-030 req_valid deasserted before acceptance SHALL not be granted; no response is generated for it.
REQ-031 Only one operation SHALL be outstanding at any time.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, rr_ptr=0, counter=0, req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, add_start=0, add_a=add_b=0.
REQ-033 add_rst_n SHALL be 0 during any cycle with rst=1, clearing the core mid-operation; the in-flight operation is discarded with no response.

Verification
REQ-034 Single op: requester 2 sends 0x3F800000 + 0x40000000 -> req_ready[2] at T, rsp_valid=4'b0100 at T+12, rsp_result=0x40400000.
REQ-035 All four requesting at once from reset -> grants in order 0,1,2,3, each rsp_valid one-hot, successive rsp_valid 13 cycles apart.
REQ-036 Fairness: requesters 0 and 3 held continuously -> grants alternate 0,3,0,3; no requester is starved.
REQ-037 Timeout: model core never raises add_done[0] -> add_rst_n low for 1 cycle after 31 ISSUE cycles, then rsp_valid[owner] with rsp_flags=4'b0001, rsp_result=0.
REQ-038 Mid-operation reset: rst=1 at T+5 -> all outputs at reset values next cycle, add_rst_n=0, no rsp_valid; a new request after rst is accepted and completes in 12 cycles.
REQ-039 Back-to-back: second request from the same requester asserted during DRAIN -> accepted at first IDLE cycle, add_done[0] again seen 10 cycles later, confirming clean core restart.
